// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the FIFO.
// master = requester/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDXW  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wren;
  logic [WIDTH-1:0]      fifo_datain;
  logic                  fifo_wrfull;
  logic [IDXW-1:0]       grant_id;
  logic                  busy;

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    output fifo_wrfull,
    input  req_ready,
    input  fifo_wren,
    input  fifo_datain,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  fifo_wrfull,
    output req_ready,
    output fifo_wren,
    output fifo_datain,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port.
// Optional stall counter: FIFO_WR_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int IDXW      = 2,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic reset_,
  fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDXW-1:0]  grant_q, grant_d;
  logic [3:0]       beat_q, beat_d;
  logic [IDXW-1:0]  pick;
  logic             found;
  logic             burst;
  logic             vg, lg;
  logic [WIDTH-1:0] dg;
  logic             acc;
  logic             rel;
  logic             last_beat;

  assign burst = (state_q == S_BURST);

  // Fetch the granted requester's valid/last/data.
  always_comb begin
    vg = 1'b0;
    lg = 1'b0;
    dg = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDXW'(i) == grant_q) begin
        vg = bus.req_valid[i];
        lg = bus.req_last[i];
        dg = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin search starting just after the last grant.
  always_comb begin
    pick  = grant_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found &&
          bus.req_valid[(int'(grant_q) + k) % NREQ]) begin
        pick  = IDXW'((int'(grant_q) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

  assign acc       = burst & vg & ~bus.fifo_wrfull;
  assign last_beat = lg | (beat_q == 4'(MAX_BURST - 1));
  assign rel       = burst & (~vg | (acc & last_beat));

  // Ready goes only to the granted requester.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (burst && IDXW'(i) == grant_q) begin
        bus.req_ready[i] = ~bus.fifo_wrfull;
      end
    end
  end

  // FIFO write side and status outputs.
  always_comb begin
    bus.fifo_wren   = acc;
    bus.fifo_datain = burst ? dg : '0;
    bus.grant_id    = grant_q;
    bus.busy        = burst;
  end

  // Next-state: grant in IDLE, count and release in BURST.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (found) begin
          state_d = S_BURST;
          grant_d = pick;
        end
      end
      (state_q == S_BURST): begin
        if (rel) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else if (acc) begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // State, grant and beat registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      grant_q <= IDXW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the granted requester waits on full.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      stall_q <= '0;
    end else if (burst && vg && bus.fifo_wrfull &&
                 stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of the one-clock FIFO (8-bit, 16-deep) among NREQ requesters. Grants are round-robin and burst-based: the granted requester keeps the port for up to MAX_BURST accepted beats, or until it signals last. Sits between the requester blocks and the FIFO write side (wren/datain/wrfull). Honours wrfull, so no write is ever issued into a full FIFO.

Parameters:
WIDTH, 8, data width; matches FIFO datain.
NREQ, 4, number of requesters (2..8).
IDXW, 2, width of grant index; must be >= clog2(NREQ).
MAX_BURST, 4, max beats per grant (1..15).

Ports:
clk  in  1  single clock, rising edge.
reset_  in  1  asynchronous, active-low reset.
req_valid  in  NREQ  per-requester data valid.
req_last  in  NREQ  per-requester end-of-burst marker, qualified by valid.
req_data  in  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
req_ready  out  NREQ  per-requester accept; one-hot or zero.
fifo_wren  out  1  FIFO write enable.
fifo_datain  out  WIDTH  FIFO write data.
fifo_wrfull  in  1  FIFO full flag.
grant_id  out  IDXW  index of the current or last granted requester.
busy  out  1  high while in BURST.

Behaviour:
- Reset (async, reset_=0): state=IDLE, grant_id=NREQ-1 (so requester 0 wins first), beat_cnt=0, busy=0, req_ready=0, fifo_wren=0.
- Two states: IDLE and BURST.
- IDLE: if any req_valid is set, select the first set bit searching from grant_id+1 upward with wrap (round-robin). Register grant_id and go to BURST next cycle. No beat is accepted in IDLE.
- BURST:
  - Let g = grant_id.
  - accept = req_valid[g] & !fifo_wrfull.
  - req_ready[g] = !fifo_wrfull. All other ready bits are 0.
  - fifo_wren = accept.
  - fifo_datain = req_data[g] (combinational mux; 0 when not in BURST).
- Beat accounting: on accept, beat_cnt += 1 (4-bit).
- Release to IDLE at the clock edge where any of these holds:
  - accept & req_last[g];
  - accept & beat_cnt == MAX_BURST-1;
  - !req_valid[g] (requester idle).
  On release, beat_cnt is cleared.
- Every release costs exactly one IDLE bubble cycle before the next grant.
- fifo_wrfull while granted: no accept and no count. Grant is held while req_valid[g] stays high; waiting on full has no timeout.
- Requester rules:
  - A requester must hold req_valid and data stable until ready.
  - Deasserting valid while not ready releases the grant; no data is lost.
- A requester whose valid is high while another holds the grant waits. Its worst-case latency is (NREQ-1)*(MAX_BURST+1) accepting cycles plus full stalls.
- Single requester continuously valid with no last: pattern of MAX_BURST beats then 1 bubble, repeating.
- Output timing: fifo_wren/req_ready are combinational from state, registered grant, req_valid and fifo_wrfull. There are no combinational paths from req_data to control.
- Reset mid-burst: grant is dropped immediately and outputs go to their reset values. The partially sent burst stays in the FIFO.

Optional Feature:
Macro FIFO_WR_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits).
  - Increments each cycle with state==BURST & req_valid[grant_id] & fifo_wrfull.
  - Saturates at 16'hFFFF.
  - Cleared only by reset_.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then req_valid=4'b0001, 3 beats, last on beat 3 (data 0x11,0x22,0x33) -> grant_id=0 one cycle after valid; fifo_wren high 3 cycles, datain 0x11,0x22,0x33; busy drops after beat 3.
- req_valid=4'b1111 held, no last, MAX_BURST=4 -> grants in order 0,1,2,3,0. Each grant gives 4 consecutive wren cycles, then 1 bubble.
- Requester 2 is granted and fifo_wrfull=1 for 5 cycles mid-burst -> fifo_wren=0 and req_ready=0 during full; beat_cnt frozen; the burst resumes with the same data; total beats = 4. With the macro defined, stall_cnt=5.
- Fill: 17 beats offered by requester 1 into a 16-deep FIFO that nothing reads (FIFO reports full at 15 entries) -> exactly 15 wren pulses; beat 16 held waiting on ready.
- Requester 3 granted; it drops valid after 1 beat while requester 0 is waiting -> release; 1 bubble; then grant_id=0.
- reset_ asserted mid-burst during the 2nd beat -> same cycle: fifo_wren=0 and busy=0. After release, requester 0 is granted first.
